// File: rtl/mc10_cas_player.sv
// -----------------------------------------------------------------------------
// mc10_cas_player
//   Cassette playback stage feeding the MC-10 core's cin input. Tape bytes
//   from the loader are queued in a small FIFO and serialised LSB-first as
//   FSK audio: a 0 bit is one 1200 Hz cycle, a 1 bit is one 2400 Hz cycle.
//
// Ports
//   clk_sys    in   system clock (single domain)
//   reset      in   asynchronous, active-high reset
//   din        in   tape byte from loader
//   din_valid  in   din holds a byte to push
//   din_ready  out  FIFO can accept; push happens on din_valid & din_ready
//   play       in   level, 1 = playback enabled
//   cin        out  square-wave cassette bit (1 while the FSM is in HI)
//   busy       out  1 while the FSM is not idle
//   underrun   out  1-cycle pulse: byte ended with play=1 and FIFO empty
//   level      out  FIFO occupancy
// -----------------------------------------------------------------------------
module mc10_cas_player #(
    parameter int CLK_HZ = 50000000,
    parameter int DEPTH  = 16,
    parameter int HALF0  = CLK_HZ / 2400,
    parameter int HALF1  = CLK_HZ / 4800
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [7:0]               din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     play,
    output logic                     cin,
    output logic                     busy,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(HALF0) + 1;

    localparam logic [CW-1:0] C_HALF0 = CW'(HALF0);
    localparam logic [CW-1:0] C_HALF1 = CW'(HALF1);
    localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HI,
        S_LO
    } state_t;

    state_t          r_state;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitidx;
    logic [CW-1:0]   r_cnt;
    logic            r_cin;
    logic            r_busy;
    logic            r_underrun;

    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_have;
    logic            w_cnt_end;
    logic [7:0]      w_head;

    // Half-period length for a given bit value.
    function automatic logic [CW-1:0] half_for(input logic b);
        return b ? C_HALF1 : C_HALF0;
    endfunction

    assign w_ready   = (r_level != C_DEPTH);
    assign w_push    = din_valid & w_ready;
    // The byte leaves the FIFO during the single LOAD cycle.
    assign w_pop     = (r_state == S_LOAD);
    assign w_have    = (r_level != '0);
    assign w_cnt_end = (r_cnt == CW'(1));
    assign w_head    = r_mem[r_rptr];

    assign din_ready = w_ready;
    assign cin       = r_cin;
    assign busy      = r_busy;
    assign underrun  = r_underrun;
    assign level     = r_level;

    // Storage is not reset; only pointers and occupancy define its contents.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Outputs are registered from the next state so cin tracks HI exactly
    // and busy tracks "not IDLE" exactly.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bitidx   <= '0;
            r_cnt      <= '0;
            r_cin      <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (play && w_have) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_shift  <= w_head;
                    r_bitidx <= '0;
                    r_cnt    <= half_for(w_head[0]);
                    r_state  <= S_HI;
                    r_cin    <= 1'b1;
                end
                S_HI: begin
                    if (w_cnt_end) begin
                        r_cnt   <= half_for(r_shift[0]);
                        r_state <= S_LO;
                        r_cin   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_LO: begin
                    if (w_cnt_end) begin
                        if (r_bitidx != 3'd7) begin
                            // Next bit is the one about to shift into bit 0.
                            r_shift  <= r_shift >> 1;
                            r_bitidx <= r_bitidx + 3'd1;
                            r_cnt    <= half_for(r_shift[1]);
                            r_state  <= S_HI;
                            r_cin    <= 1'b1;
                        end else if (play && w_have) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_underrun <= play;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cin   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc10_cas_player.sv
// -----------------------------------------------------------------------------
// tb_mc10_cas_player
//   Drives directed scenarios and a random phase into mc10_cas_player and
//   compares every cycle against a waveform-level reference: each started
//   byte expands into one low LOAD cycle followed by, per bit LSB-first,
//   HALF cycles high and HALF cycles low.
// -----------------------------------------------------------------------------
module tb_mc10_cas_player;

    localparam int DEPTH = 4;
    localparam int HALF0 = 20;
    localparam int HALF1 = 10;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        play;
    logic        cin;
    logic        busy;
    logic        underrun;
    logic [2:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_wave[$];
    bit         m_pop_next;
    bit         m_busy;
    bit         e_cin;
    bit         e_busy;
    bit         e_und;

    mc10_cas_player #(
        .CLK_HZ (48000),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .play      (play),
        .cin       (cin),
        .busy      (busy),
        .underrun  (underrun),
        .level     (level)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_wave.delete();
        m_pop_next = 1'b0;
        m_busy     = 1'b0;
        e_cin      = 1'b0;
        e_busy     = 1'b0;
        e_und      = 1'b0;
    endtask

    // One clock edge of the reference, given the inputs sampled on that edge.
    task automatic model_edge(input bit v, input logic [7:0] d, input bit p);
        int         occ;
        bit         prev_busy;
        bit         start_pop;
        logic [7:0] b;
        int         h;
        occ       = m_q.size();
        prev_busy = m_busy;
        start_pop = 1'b0;
        e_und     = 1'b0;
        if (m_wave.size() != 0) begin
            e_cin  = m_wave.pop_front();
            m_busy = 1'b1;
        end else if (p && occ != 0) begin
            b = m_q[0];
            m_wave.push_back(1'b0);
            for (int i = 0; i < 8; i++) begin
                h = b[i] ? HALF1 : HALF0;
                repeat (h) m_wave.push_back(1'b1);
                repeat (h) m_wave.push_back(1'b0);
            end
            e_cin     = m_wave.pop_front();
            m_busy    = 1'b1;
            start_pop = 1'b1;
        end else begin
            e_cin  = 1'b0;
            m_busy = 1'b0;
            e_und  = prev_busy && p;
        end
        e_busy = m_busy;
        if (m_pop_next) void'(m_q.pop_front());
        if (v && occ != DEPTH) m_q.push_back(d);
        m_pop_next = start_pop;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit p);
        din_valid = v;
        din       = d;
        play      = p;
        @(posedge clk_sys);
        model_edge(v, d, p);
        #1;
        chk("cin",       cin,       e_cin);
        chk("busy",      busy,      e_busy);
        chk("underrun",  underrun,  e_und);
        chk("level",     level,     m_q.size());
        chk("din_ready", din_ready, (m_q.size() != DEPTH));
    endtask

    task automatic run(input int n, input bit p);
        repeat (n) step(1'b0, 8'h00, p);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_cin",      cin,      0);
        chk("rst_busy",     busy,     0);
        chk("rst_underrun", underrun, 0);
        chk("rst_level",    level,    0);
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        chk("rst_hold_cin",   cin,       0);
        chk("rst_hold_ready", din_ready, 1);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        bit p;
        din_valid = 1'b0;
        din       = 8'h00;
        play      = 1'b0;
        model_clear();
        do_reset();

        // Single 0x55 then underrun
        step(1'b1, 8'h55, 1'b0);
        run(270, 1'b1);

        // 0x00 and 0xFF back to back
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        run(500, 1'b1);

        // Fill while stopped, then keep pushing during playback, then drain
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 700; i++) step(1'b1, 8'($urandom), 1'b1);
        run(1400, 1'b1);

        // Drop play during bit 3 of 0xA5; next byte stays queued
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        run(90, 1'b1);
        run(300, 1'b0);

        // Reset during HI of bit 2 of 0x3C, then play into an empty FIFO
        run(85, 1'b1);
        chk("pre_reset_cin", cin, 1);
        do_reset();
        run(100, 1'b1);

        // Random traffic
        p = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) p = ~p;
            if ($urandom_range(0, 999) == 0) do_reset();
            else step(($urandom_range(0, 3) == 0), 8'($urandom), p);
        end
        run(1400, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
